// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register: hold / shift right / shift left / load,
// plus an autonomous WIDTH-shift burst. Define USR_ROTATE_EN to add the rot input.
module universal_shift_register #(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
`ifdef USR_ROTATE_EN
  input  logic             rot,
`endif
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             start,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               rot_c;
  logic               fill_r_c;
  logic               fill_l_c;
  logic [WIDTH-1:0]   shr_c;
  logic [WIDTH-1:0]   shl_c;

`ifdef USR_ROTATE_EN
  assign rot_c = rot;
`else
  assign rot_c = 1'b0;
`endif

  // Shift candidates; rotate feeds the outgoing bit back in as the fill bit
  assign fill_r_c = rot_c ? q_q[0]       : sin_r;
  assign fill_l_c = rot_c ? q_q[WIDTH-1] : sin_l;
  assign shr_c    = {fill_r_c, q_q[WIDTH-1:1]};
  assign shl_c    = {q_q[WIDTH-2:0], fill_l_c};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      q_q     <= RESET_VAL;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state: start beats mode in IDLE; BURST ignores mode/start/dir
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dir_d   = dir;
          q_d     = dir ? shl_c : shr_c;
          cnt_d   = CNT_W'(1);
          busy_d  = 1'b1;
          state_d = S_BURST;
        end else begin
          unique case (mode)
            2'b00: q_d = q_q;
            2'b01: q_d = shr_c;
            2'b10: q_d = shl_c;
            2'b11: q_d = d;
          endcase
        end
      end
      S_BURST: begin
        q_d = dir_q ? shl_c : shr_c;
        // This edge performs the last shift when WIDTH-1 are already done
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  assign q      = q_q;
  assign qn     = ~q_q;
  assign sout_r = q_q[0];
  assign sout_l = q_q[WIDTH-1];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed self-checking bench for universal_shift_register (WIDTH=4, RESET_VAL=0).
module tb_universal_shift_register;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic [1:0]   mode;
  logic [W-1:0] d;
  logic         sin_r;
  logic         sin_l;
  logic         start;
  logic         dir;
  logic [W-1:0] q;
  logic [W-1:0] qn;
  logic         sout_r;
  logic         sout_l;
  logic         busy;
  logic         done;
`ifdef USR_ROTATE_EN
  logic         rot;
`endif

  int errors;
  int checks;

  universal_shift_register #(
    .WIDTH     (W),
    .RESET_VAL (4'b0000)
  ) dut (
    .clk    (clk),
    .rst    (rst),
`ifdef USR_ROTATE_EN
    .rot    (rot),
`endif
    .mode   (mode),
    .d      (d),
    .sin_r  (sin_r),
    .sin_l  (sin_l),
    .start  (start),
    .dir    (dir),
    .q      (q),
    .qn     (qn),
    .sout_r (sout_r),
    .sout_l (sout_l),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // q plus the two status flags after an edge
  task automatic chk_st(input string tag, input logic [W-1:0] eq, input logic eb, input logic ed);
    chk4({tag, ".q"}, q, eq);
    chk1({tag, ".busy"}, busy, eb);
    chk1({tag, ".done"}, done, ed);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    mode   = 2'b00;
    d      = '0;
    sin_r  = 1'b0;
    sin_l  = 1'b0;
    start  = 1'b0;
    dir    = 1'b0;
`ifdef USR_ROTATE_EN
    rot    = 1'b0;
`endif

    // 1. Reset from an arbitrary value
    mode = 2'b11; d = 4'b0110;
    tick();
    chk4("pre_reset_load", q, 4'b0110);
    mode = 2'b00; rst = 1'b1;
    tick();
    tick();
    chk_st("reset", 4'b0000, 1'b0, 1'b0);
    chk4("reset.qn", qn, 4'b1111);
    rst = 1'b0;

    // 2. Load and hold
    mode = 2'b11; d = 4'b1011;
    tick();
    chk4("load.q", q, 4'b1011);
    chk4("load.qn", qn, 4'b0100);
    chk1("load.sout_r", sout_r, 1'b1);
    chk1("load.sout_l", sout_l, 1'b1);
    mode = 2'b00; d = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk4("hold.q", q, 4'b1011);
    end

    // 3. Manual shifts
    mode = 2'b01; sin_r = 1'b1;
    tick();
    chk4("shr.q", q, 4'b1101);
    mode = 2'b10; sin_l = 1'b0;
    tick();
    chk4("shl.q", q, 4'b1010);
    chk1("shl.sout_r", sout_r, 1'b0);
    chk1("shl.sout_l", sout_l, 1'b1);

    // 4. Right burst with a conflicting load driven throughout
    mode = 2'b00; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk4("b4.reset.q", q, 4'b0000);
    mode = 2'b11; d = 4'b0101; sin_r = 1'b1; start = 1'b1; dir = 1'b0;
    tick();
    chk_st("b4.e1", 4'b1000, 1'b1, 1'b0);
    start = 1'b0;
    tick();
    chk_st("b4.e2", 4'b1100, 1'b1, 1'b0);
    tick();
    chk_st("b4.e3", 4'b1110, 1'b1, 1'b0);
    tick();
    chk_st("b4.e4", 4'b1111, 1'b0, 1'b1);
    tick();
    chk_st("b4.after", 4'b0101, 1'b0, 1'b0);
    mode = 2'b00;

    // 5. Reset mid-burst, then a clean left burst
    sin_l = 1'b1; start = 1'b1; dir = 1'b1;
    tick();
    chk_st("b5.e1", 4'b1011, 1'b1, 1'b0);
    start = 1'b0;
    tick();
    chk_st("b5.e2", 4'b0111, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    chk_st("b5.rst", 4'b0000, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_st("b5.idle", 4'b0000, 1'b0, 1'b0);
    tick();
    chk_st("b5.idle2", 4'b0000, 1'b0, 1'b0);
    start = 1'b1; dir = 1'b1;
    tick();
    chk_st("b5n.e1", 4'b0001, 1'b1, 1'b0);
    start = 1'b0; dir = 1'b0; mode = 2'b01;
    tick();
    chk_st("b5n.e2", 4'b0011, 1'b1, 1'b0);
    tick();
    chk_st("b5n.e3", 4'b0111, 1'b1, 1'b0);
    // Restart on the done cycle: right burst shifting in zeros
    sin_r = 1'b0; start = 1'b1; dir = 1'b0;
    tick();
    chk_st("b5n.e4", 4'b1111, 1'b0, 1'b1);
    tick();
    chk_st("b6.e1", 4'b0111, 1'b1, 1'b0);
    start = 1'b0; dir = 1'b1; mode = 2'b10;
    tick();
    chk_st("b6.e2", 4'b0011, 1'b1, 1'b0);
    tick();
    chk_st("b6.e3", 4'b0001, 1'b1, 1'b0);
    tick();
    chk_st("b6.e4", 4'b0000, 1'b0, 1'b1);
    mode = 2'b00;
    tick();
    chk_st("b6.after", 4'b0000, 1'b0, 1'b0);

`ifdef USR_ROTATE_EN
    // 6. Rotate: manual right rotate, then a full left rotate burst
    mode = 2'b11; d = 4'b1001;
    tick();
    mode = 2'b01; rot = 1'b1; sin_r = 1'b0;
    tick();
    chk4("rot.shr", q, 4'b1100);
    mode = 2'b00; start = 1'b1; dir = 1'b1; sin_l = 1'b0;
    tick();
    chk_st("rot.e1", 4'b1001, 1'b1, 1'b0);
    start = 1'b0;
    tick();
    chk_st("rot.e2", 4'b0011, 1'b1, 1'b0);
    tick();
    chk_st("rot.e3", 4'b0110, 1'b1, 1'b0);
    tick();
    chk_st("rot.e4", 4'b1100, 1'b0, 1'b1);
    rot = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
